// File: rtl/somador_serial_param.sv
// -----------------------------------------------------------------------------
// somador_serial_param
//   Digit-serial adder/subtractor. Each RUN cycle adds DIGIT bits, least
//   significant digit first, and keeps the carry in a register between digits.
//   A start/busy/done handshake sequences operations. Results are published
//   only when an operation completes, so partial sums are never visible.
//
// Parameters
//   WIDTH  operand width in bits (a multiple of DIGIT)
//   DIGIT  bits processed per clock; DIGIT == WIDTH gives single-cycle add
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request, accepted in IDLE or DONE
//   sub        0: num1 + num2, 1: num1 - num2 (sampled with start)
//   num1/num2  operands (sampled with start)
//   busy       high while digits are processed (RUN)
//   done       one-cycle pulse: resultado/overflow were just updated
//   resultado  [WIDTH-1:0] sum/difference, [WIDTH] carry (add) / borrow (sub)
//   overflow   signed two's-complement overflow of the last operation
// -----------------------------------------------------------------------------
module somador_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   resultado,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("somador_serial_param: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, shadow_q;
  logic             sub_q, a_sign_q, b_sign_q, carry_q;
  logic [CW-1:0]    count_q;

  logic [DIGIT-1:0] a_dig, b_dig, dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] merged;
  logic             last_digit, load, ovf_next;

  // Operands are shifted right every RUN cycle, so the active digit is always
  // the low DIGIT bits; the shadow register fills from the top, which leaves
  // the full result aligned after N digits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_dig    = a_q[DIGIT-1:0];
    b_dig    = sub_q ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    {dig_cout, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry_q);
    merged   = (shadow_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
    last_digit = (count_q == LAST);
    load     = start && (state_q != RUN);
    // Original operand signs are kept apart because the operand registers
    // are consumed by the shifting.
    ovf_next = sub_q ? ((a_sign_q != b_sign_q) && (merged[WIDTH-1] != a_sign_q))
                     : ((a_sign_q == b_sign_q) && (merged[WIDTH-1] != a_sign_q));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      shadow_q  <= '0;
      sub_q     <= 1'b0;
      a_sign_q  <= 1'b0;
      b_sign_q  <= 1'b0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      resultado <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q      <= num1;
        b_q      <= num2;
        sub_q    <= sub;
        a_sign_q <= num1[WIDTH-1];
        b_sign_q <= num2[WIDTH-1];
        carry_q  <= sub;           // +1 of the two's complement of num2
        count_q  <= '0;
      end else if (state_q == RUN) begin
        a_q      <= a_q >> DIGIT;
        b_q      <= b_q >> DIGIT;
        shadow_q <= merged;
        carry_q  <= dig_cout;
        count_q  <= last_digit ? '0 : count_q + CW'(1);
        if (last_digit) begin
          // Subtraction reports borrow, the inverse of the final carry.
          resultado <= {sub_q ? ~dig_cout : dig_cout, merged};
          overflow  <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_somador_serial_param.sv
// -----------------------------------------------------------------------------
// tb_somador_serial_param
//   Scoreboard bench. The main instance (WIDTH=8, DIGIT=4) takes directed
//   operations; four more instances (8/1, 8/2, 8/8, 16/4) join the random
//   phase. Expected results come from signed/unsigned integer arithmetic and
//   are queued at issue time; per-instance monitors pop on every done pulse.
// -----------------------------------------------------------------------------
module tb_somador_serial_param;

  typedef struct {
    logic [16:0] r;
    logic        o;
    int          c;   // cycle index of the accepting edge
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance stimulus
  logic       start_m = 1'b0, sub_m = 1'b0;
  logic [7:0] a_m = '0, b_m = '0;
  // Random-group stimulus
  logic        start_r = 1'b0, sub_r = 1'b0;
  logic [15:0] a_r = '0, b_r = '0;

  logic       busy_m, done_m, ov_m;
  logic [8:0] res_m;
  logic       busy_1, done_1, ov_1, busy_2, done_2, ov_2, busy_8, done_8, ov_8;
  logic [8:0] res_1, res_2, res_8;
  logic        busy_w, done_w, ov_w;
  logic [16:0] res_w;

  somador_serial_param #(.WIDTH(8), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_m), .sub(sub_m), .num1(a_m), .num2(b_m),
    .busy(busy_m), .done(done_m), .resultado(res_m), .overflow(ov_m));
  somador_serial_param #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_r), .sub(sub_r), .num1(a_r[7:0]), .num2(b_r[7:0]),
    .busy(busy_1), .done(done_1), .resultado(res_1), .overflow(ov_1));
  somador_serial_param #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_r), .sub(sub_r), .num1(a_r[7:0]), .num2(b_r[7:0]),
    .busy(busy_2), .done(done_2), .resultado(res_2), .overflow(ov_2));
  somador_serial_param #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start_r), .sub(sub_r), .num1(a_r[7:0]), .num2(b_r[7:0]),
    .busy(busy_8), .done(done_8), .resultado(res_8), .overflow(ov_8));
  somador_serial_param #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start_r), .sub(sub_r), .num1(a_r), .num2(b_r),
    .busy(busy_w), .done(done_w), .resultado(res_w), .overflow(ov_w));

  // Index 0: main 8/4, 1: 8/1, 2: 8/2, 3: 8/8, 4: 16/4
  exp_t exp_q[5][$];
  int   done_hist[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the w-bit operands.
  function automatic exp_t model(input int w, input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint full = longint'(1) << w;
    longint half = full / 2;
    longint ua = longint'(a) % full;
    longint ub = longint'(b) % full;
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint sr;
    if (!s) begin
      e.r = 17'(ua + ub);
      sr  = sa + sb;
    end else begin
      e.r = 17'(((ua - ub) % full + full) % full);
      if (ua < ub) e.r = e.r | 17'(full);
      sr  = sa - sb;
    end
    e.o = (sr >= half) || (sr < -half);
    e.c = 0;
    return e;
  endfunction

  task automatic mon(input int k, input logic [16:0] r, input logic o, input int n);
    exp_t e;
    string nm;
    nm = $sformatf("inst%0d", k);
    check({nm, "_done_expected"}, 32'(exp_q[k].size() != 0), 32'd1);
    if (exp_q[k].size() != 0) begin
      e = exp_q[k].pop_front();
      check({nm, "_resultado"}, 32'(r), 32'(e.r));
      check({nm, "_overflow"}, 32'(o), 32'(e.o));
      check({nm, "_latency"}, 32'(cyc - e.c), 32'(n));
    end
    if (k == 0) done_hist.push_back(cyc);
  endtask

  always @(negedge clk) if (done_m) mon(0, 17'(res_m), ov_m, 2);
  always @(negedge clk) if (done_1) mon(1, 17'(res_1), ov_1, 8);
  always @(negedge clk) if (done_2) mon(2, 17'(res_2), ov_2, 4);
  always @(negedge clk) if (done_8) mon(3, 17'(res_8), ov_8, 1);
  always @(negedge clk) if (done_w) mon(4, res_w, ov_w, 4);

  // Call just after a falling edge; returns just after the accepting edge.
  task automatic issue_m(input bit s, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    start_m = 1'b1; sub_m = s; a_m = a; b_m = b;
    e = model(8, s, 16'(a), 16'(b));
    @(posedge clk); #1;
    e.c = cyc;
    exp_q[0].push_back(e);
    start_m = 1'b0;
  endtask

  task automatic wait_empty(input int max_cycles);
    int left;
    left = 0;
    for (int i = 0; i < max_cycles; i++) begin
      left = 0;
      for (int k = 0; k < 5; k++) left += exp_q[k].size();
      if (left == 0) break;
      @(negedge clk); #1;
    end
    left = 0;
    for (int k = 0; k < 5; k++) left += exp_q[k].size();
    check("drain_timeout", 32'(left), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          s, seen;
    logic [15:0] a, b;
    exp_t        e;

    // 1: reset for two edges with start asserted
    start_m = 1'b1; a_m = 8'hFF; b_m = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_resultado", 32'(res_m), 32'h000);
    check("rst_overflow", 32'(ov_m), 32'd0);
    start_m = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 32'(busy_m), 32'd0);
    end

    // 2/3: boundary operations
    issue_m(1'b0, 8'hFF, 8'h01);
    wait_empty(20);
    check("ff_plus_01", 32'(res_m), 32'h100);
    @(negedge clk); issue_m(1'b0, 8'h7F, 8'h01);
    wait_empty(20);
    check("7f_plus_01", 32'(res_m), 32'h080);
    check("7f_plus_01_ovf", 32'(ov_m), 32'd1);
    @(negedge clk); issue_m(1'b1, 8'h05, 8'h07);
    wait_empty(20);
    check("05_minus_07", 32'(res_m), 32'h1FE);
    @(negedge clk); issue_m(1'b1, 8'h00, 8'h01);
    wait_empty(20);
    check("00_minus_01", 32'(res_m), 32'h1FF);

    // 4: start while busy is ignored
    @(negedge clk); issue_m(1'b0, 8'h12, 8'h34);
    @(negedge clk);
    check("busy_in_run", 32'(busy_m), 32'd1);
    start_m = 1'b1; sub_m = 1'b1; a_m = 8'hAA; b_m = 8'h55;
    @(posedge clk); #1; start_m = 1'b0;
    wait_empty(20);
    check("ignored_start_result", 32'(res_m), 32'h046);
    // back-to-back: start held in DONE
    @(negedge clk); issue_m(1'b1, 8'h80, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_m) begin seen = 1'b1; break; end
    end
    check("b2b_first_done", 32'(seen), 32'd1);
    issue_m(1'b0, 8'h40, 8'h40);
    wait_empty(20);
    check("b2b_result", 32'(res_m), 32'h080);
    check("b2b_done_spacing", 32'(done_hist[$] - done_hist[$-1]), 32'd3);

    // 5: reset mid-RUN aborts the operation
    @(negedge clk); issue_m(1'b0, 8'h11, 8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_resultado", 32'(res_m), 32'h000);
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_overflow", 32'(ov_m), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_m), 32'd0);
    end
    @(negedge clk); issue_m(1'b0, 8'h11, 8'h22);
    wait_empty(20);
    check("after_abort", 32'(res_m), 32'h033);

    // 6: random operations on all instances
    void'($urandom(12430));
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      s = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      start_m = 1'b1; sub_m = s; a_m = a[7:0]; b_m = b[7:0];
      start_r = 1'b1; sub_r = s; a_r = a;      b_r = b;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
        e = model((k == 4) ? 16 : 8, s, a, b);
        e.c = cyc;
        exp_q[k].push_back(e);
      end
      start_m = 1'b0; start_r = 1'b0;
      // operand changes during RUN must not matter
      sub_m = ~s; sub_r = ~s;
      a_r = 16'($urandom); b_r = 16'($urandom);
      a_m = a_r[7:0]; b_m = b_r[7:0];
      wait_empty(30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
